mem_port_arbiter: RTL

//  Round-robin arbiter sharing the single RAM port between N_REQ requesters (conv/pool/FC sequencers).

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one RAM port; req->gnt 1 cycle, mem_finish->done 1 cycle, done then one idle cycle.
// Requesters hold req until their done; the RAM stalls via mem_finish and a watchdog aborts with err.
module mem_port_arbiter #(
   parameter int N_REQ   = 3,
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ-1:0]    req_wr,
   input  logic [N_REQ*DW-1:0] req_wdata,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    done,
   output logic                err,
   output logic [DW-1:0]       rdata,
   output logic                busy,
   output logic                mem_enable,
   output logic [AW-1:0]       mem_address,
   output logic                mem_write,
   output logic [DW-1:0]       mem_wdata,
   input  logic [DW-1:0]       mem_rdata,
   input  logic                mem_finish
);

   localparam int IW = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [IW-1:0]    rr_ptr, rr_nxt;
   logic [IW-1:0]    cur_idx, idx_nxt;
   logic [15:0]      wd_cnt, wd_nxt;

   logic             pick_vld;
   logic [IW-1:0]    pick_idx;
   int               scan_j;

   logic [N_REQ-1:0] gnt_nxt, done_nxt;
   logic             err_nxt, en_nxt, wr_nxt;
   logic [DW-1:0]    rdata_nxt, wdata_nxt;
   logic [AW-1:0]    addr_nxt;

   // First set request at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      scan_j   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_j = int'(rr_ptr) + k;
         if (scan_j >= N_REQ) scan_j = scan_j - N_REQ;
         if (!pick_vld && req[scan_j]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(scan_j);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      idx_nxt   = cur_idx;
      wd_nxt    = wd_cnt;
      gnt_nxt   = gnt;
      done_nxt  = '0;
      err_nxt   = err;
      rdata_nxt = rdata;
      en_nxt    = mem_enable;
      addr_nxt  = mem_address;
      wr_nxt    = mem_write;
      wdata_nxt = mem_wdata;
      case (state)
         S_IDLE: begin
            gnt_nxt = '0;
            err_nxt = 1'b0;
            en_nxt  = 1'b0;
            wr_nxt  = 1'b0;
            if (pick_vld) begin
               state_nxt = S_WAIT;
               idx_nxt   = pick_idx;
               wd_nxt    = '0;
               gnt_nxt   = ONE << pick_idx;
               en_nxt    = 1'b1;
               addr_nxt  = req_addr[int'(pick_idx)*AW +: AW];
               wr_nxt    = req_wr[pick_idx];
               wdata_nxt = req_wdata[int'(pick_idx)*DW +: DW];
            end
         end
         S_WAIT: begin
            // A finish on the watchdog's last cycle still counts as success.
            if (mem_finish) begin
               state_nxt = S_DONE;
               done_nxt  = ONE << cur_idx;
               err_nxt   = 1'b0;
               rdata_nxt = mem_write ? '0 : mem_rdata;
               en_nxt    = 1'b0;
               wr_nxt    = 1'b0;
            end else if (wd_cnt == 16'(TIMEOUT)) begin
               state_nxt = S_DONE;
               done_nxt  = ONE << cur_idx;
               err_nxt   = 1'b1;
               rdata_nxt = '0;
               en_nxt    = 1'b0;
               wr_nxt    = 1'b0;
            end else begin
               wd_nxt = wd_cnt + 16'd1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
            gnt_nxt   = '0;
            err_nxt   = 1'b0;
            en_nxt    = 1'b0;
            wr_nxt    = 1'b0;
            if (int'(cur_idx) == N_REQ - 1) rr_nxt = '0;
            else                            rr_nxt = cur_idx + IW'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         cur_idx     <= '0;
         wd_cnt      <= '0;
         gnt         <= '0;
         done        <= '0;
         err         <= 1'b0;
         rdata       <= '0;
         busy        <= 1'b0;
         mem_enable  <= 1'b0;
         mem_address <= '0;
         mem_write   <= 1'b0;
         mem_wdata   <= '0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_nxt;
         cur_idx     <= idx_nxt;
         wd_cnt      <= wd_nxt;
         gnt         <= gnt_nxt;
         done        <= done_nxt;
         err         <= err_nxt;
         rdata       <= rdata_nxt;
         busy        <= (state_nxt != S_IDLE);
         mem_enable  <= en_nxt;
         mem_address <= addr_nxt;
         mem_write   <= wr_nxt;
         mem_wdata   <= wdata_nxt;
      end
   end

endmodule
